vend_txn_controller: RTL and testbench

Transaction controller for the three-item nickel/dime vending machine. It latches an item selection, accumulates coin credit against a per-item price, and sequences the dispenser mechanism and the nickel-return mechanism through req/ack handshakes. It also handles cancel and inactivity refunds. It sits between the coin/keypad front end and the dispense and change actuators, replacing free-running per-item state machines with one arbitrated sequencer.

---
 rtl/vend_txn_controller.sv | 227 ++++++++++++++++++++++
 tb/tb_vend_txn_controller.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/vend_txn_controller.sv
// vend_txn_controller: one sequencer for the three-item nickel/dime vending machine.
// Latches an item price, collects coin credit, then drives the dispenser and the
// nickel-return mechanism through req/ack handshakes. Also handles cancel refunds.
// Optional feature macro: VEND_TIMEOUT_EN. When it is defined, an inactivity
// counter in COLLECT forces a refund (or a return to IDLE when there is no credit)
// after TIMEOUT_CYC idle cycles.
// All outputs come straight from flops. State-decoded requests are registered from
// the next state, so each one rises on the same edge that enters its state.
module vend_txn_controller #(
   parameter int PRICE0      = 3,
   parameter int PRICE1      = 4,
   parameter int PRICE2      = 5,
   parameter int TIMEOUT_CYC = 1000
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [1:0] item_sel,
   input  logic       item_valid,
   input  logic       nickel_in,
   input  logic       dime_in,
   input  logic       cancel,
   input  logic       dispense_ack,
   input  logic       nickel_out_ack,
   output logic       dispense_req,
   output logic       nickel_out_req,
   output logic       coin_reject,
   output logic       sel_err,
   output logic       vend_done,
   output logic       refund_done,
   output logic [3:0] credit,
   output logic       busy
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_COLLECT = 3'd1,
      ST_VEND    = 3'd2,
      ST_CHANGE  = 3'd3,
      ST_REFUND  = 3'd4
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] credit_q, credit_d;
   logic [3:0] price_q, price_d;
   logic       coin_reject_q, coin_reject_d;
   logic       sel_err_q, sel_err_d;
   logic       vend_done_q, vend_done_d;
   logic       refund_done_q, refund_done_d;
   logic       dispense_req_q, dispense_req_d;
   logic       nickel_out_req_q, nickel_out_req_d;
   logic       busy_q, busy_d;
   logic [3:0] coin_add_s;
   logic [3:0] credit_upd_s;
   logic       timeout_s;

   // Maps a valid item code to its price in nickels; code 3 never reaches here.
   function automatic logic [3:0] price_of(input logic [1:0] sel);
      logic [3:0] p;
      case (sel)
         2'd0:    p = 4'(PRICE0);
         2'd1:    p = 4'(PRICE1);
         2'd2:    p = 4'(PRICE2);
         default: p = 4'd0;
      endcase
      return p;
   endfunction

`ifdef VEND_TIMEOUT_EN
   localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   logic [TW-1:0] timer_q, timer_d;

   // Inactivity counter: cleared outside COLLECT (so it is zero on entry) and on every credited coin.
   always_comb begin
      timer_d = timer_q;
      if ((state_q != ST_COLLECT) || (coin_add_s != 4'd0)) begin
         timer_d = '0;
      end else begin
         timer_d = timer_q + TW'(1);
      end
   end

   // Inactivity counter register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_d;
      end
   end

   assign timeout_s = (timer_q == TW'(TIMEOUT_CYC - 1));
`else
   assign timeout_s = 1'b0;
`endif

   // Coin credit in COLLECT: a dime wins over a same-cycle nickel, which is rejected.
   always_comb begin
      coin_add_s = 4'd0;
      if (state_q == ST_COLLECT) begin
         if (dime_in) begin
            coin_add_s = 4'd2;
         end else if (nickel_in) begin
            coin_add_s = 4'd1;
         end else begin
            coin_add_s = 4'd0;
         end
      end else begin
         coin_add_s = 4'd0;
      end
      credit_upd_s = credit_q + coin_add_s;
   end

   // Next-state, credit and one-cycle pulse logic for the transaction sequencer.
   always_comb begin
      state_d       = state_q;
      credit_d      = credit_q;
      price_d       = price_q;
      coin_reject_d = 1'b0;
      sel_err_d     = 1'b0;
      vend_done_d   = 1'b0;
      refund_done_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            coin_reject_d = nickel_in | dime_in;
            if (item_valid) begin
               if (item_sel == 2'd3) begin
                  sel_err_d = 1'b1;
               end else begin
                  price_d  = price_of(item_sel);
                  credit_d = 4'd0;
                  state_d  = ST_COLLECT;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_COLLECT: begin
            coin_reject_d = nickel_in & dime_in;
            credit_d      = credit_upd_s;
            // Reaching the price beats a same-cycle cancel or timeout.
            if (credit_upd_s >= price_q) begin
               state_d = ST_VEND;
            end else if (cancel || (timeout_s && (coin_add_s == 4'd0))) begin
               state_d = (credit_upd_s != 4'd0) ? ST_REFUND : ST_IDLE;
            end else begin
               state_d = ST_COLLECT;
            end
         end
         ST_VEND: begin
            coin_reject_d = nickel_in | dime_in;
            if (dispense_ack) begin
               credit_d = credit_q - price_q;
               if ((credit_q - price_q) != 4'd0) begin
                  state_d = ST_CHANGE;
               end else begin
                  state_d     = ST_IDLE;
                  vend_done_d = 1'b1;
               end
            end else begin
               state_d = ST_VEND;
            end
         end
         ST_CHANGE, ST_REFUND: begin
            coin_reject_d = nickel_in | dime_in;
            // A zero credit here cannot be reached normally; finishing keeps the machine from sticking.
            if ((credit_q == 4'd0) || (nickel_out_ack && (credit_q == 4'd1))) begin
               credit_d      = 4'd0;
               state_d       = ST_IDLE;
               vend_done_d   = (state_q == ST_CHANGE);
               refund_done_d = (state_q == ST_REFUND);
            end else if (nickel_out_ack) begin
               credit_d = credit_q - 4'd1;
            end else begin
               credit_d = credit_q;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            credit_d = 4'd0;
         end
      endcase
   end

   // Output decode from the next state so requests and busy line up with the state register.
   always_comb begin
      dispense_req_d   = (state_d == ST_VEND);
      nickel_out_req_d = ((state_d == ST_CHANGE) || (state_d == ST_REFUND)) && (credit_d != 4'd0);
      busy_d           = (state_d != ST_IDLE);
   end

   // State, credit, price and registered output flops; reset discards any in-flight credit.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q          <= ST_IDLE;
         credit_q         <= 4'd0;
         price_q          <= 4'd0;
         coin_reject_q    <= 1'b0;
         sel_err_q        <= 1'b0;
         vend_done_q      <= 1'b0;
         refund_done_q    <= 1'b0;
         dispense_req_q   <= 1'b0;
         nickel_out_req_q <= 1'b0;
         busy_q           <= 1'b0;
      end else begin
         state_q          <= state_d;
         credit_q         <= credit_d;
         price_q          <= price_d;
         coin_reject_q    <= coin_reject_d;
         sel_err_q        <= sel_err_d;
         vend_done_q      <= vend_done_d;
         refund_done_q    <= refund_done_d;
         dispense_req_q   <= dispense_req_d;
         nickel_out_req_q <= nickel_out_req_d;
         busy_q           <= busy_d;
      end
   end

   assign dispense_req   = dispense_req_q;
   assign nickel_out_req = nickel_out_req_q;
   assign coin_reject    = coin_reject_q;
   assign sel_err        = sel_err_q;
   assign vend_done      = vend_done_q;
   assign refund_done    = refund_done_q;
   assign credit         = credit_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_vend_txn_controller.sv
// Directed self-checking bench for vend_txn_controller.
// Inputs change #1 after a rising edge; outputs are checked at that same point.
module tb_vend_txn_controller;

   logic       clock = 1'b0;
   logic       reset_n;
   logic [1:0] item_sel;
   logic       item_valid;
   logic       nickel_in;
   logic       dime_in;
   logic       cancel;
   logic       dispense_ack;
   logic       nickel_out_ack;
   logic       dispense_req;
   logic       nickel_out_req;
   logic       coin_reject;
   logic       sel_err;
   logic       vend_done;
   logic       refund_done;
   logic [3:0] credit;
   logic       busy;

   int checks = 0;
   int errors = 0;

   vend_txn_controller #(
      .PRICE0(3), .PRICE1(4), .PRICE2(5), .TIMEOUT_CYC(8)
   ) dut (
      .clock(clock), .reset_n(reset_n), .item_sel(item_sel), .item_valid(item_valid),
      .nickel_in(nickel_in), .dime_in(dime_in), .cancel(cancel),
      .dispense_ack(dispense_ack), .nickel_out_ack(nickel_out_ack),
      .dispense_req(dispense_req), .nickel_out_req(nickel_out_req),
      .coin_reject(coin_reject), .sel_err(sel_err), .vend_done(vend_done),
      .refund_done(refund_done), .credit(credit), .busy(busy)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic select(input logic [1:0] sel);
      item_sel = sel; item_valid = 1'b1; tick(); item_valid = 1'b0;
   endtask

   task automatic nickel();
      nickel_in = 1'b1; tick(); nickel_in = 1'b0;
   endtask

   task automatic dime();
      dime_in = 1'b1; tick(); dime_in = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; item_sel = 2'd0; item_valid = 1'b0; nickel_in = 1'b0; dime_in = 1'b0;
      cancel = 1'b0; dispense_ack = 1'b0; nickel_out_ack = 1'b0;
      tick(); tick();
      chk("rst_credit", 8'(credit), 8'd0);
      chk("rst_busy", 8'(busy), 8'd0);
      chk("rst_dreq", 8'(dispense_req), 8'd0);
      chk("rst_nreq", 8'(nickel_out_req), 8'd0);
      reset_n = 1'b1;
      tick();

      // Coin in IDLE is rejected, stray ack in IDLE ignored.
      nickel();
      chk("idle_rej", 8'(coin_reject), 8'd1);
      chk("idle_credit", 8'(credit), 8'd0);
      dispense_ack = 1'b1; tick(); dispense_ack = 1'b0;
      chk("idle_rej_clr", 8'(coin_reject), 8'd0);
      chk("idle_ack_busy", 8'(busy), 8'd0);

      // Item 0: nickel then dime -> exact price.
      select(2'd0);
      chk("t1_busy", 8'(busy), 8'd1);
      nickel();
      chk("t1_cr1", 8'(credit), 8'd1);
      chk("t1_noreq", 8'(dispense_req), 8'd0);
      dime();
      chk("t1_cr3", 8'(credit), 8'd3);
      chk("t1_dreq", 8'(dispense_req), 8'd1);
      dispense_ack = 1'b1; tick(); dispense_ack = 1'b0;
      chk("t1_cr0", 8'(credit), 8'd0);
      chk("t1_done", 8'(vend_done), 8'd1);
      chk("t1_dreq0", 8'(dispense_req), 8'd0);
      chk("t1_nreq0", 8'(nickel_out_req), 8'd0);
      chk("t1_idle", 8'(busy), 8'd0);
      tick();
      chk("t1_done_clr", 8'(vend_done), 8'd0);

      // Item 2: three dimes -> credit 6, one nickel of change.
      select(2'd2);
      dime(); chk("t2_cr2", 8'(credit), 8'd2);
      dime(); chk("t2_cr4", 8'(credit), 8'd4);
      dime(); chk("t2_cr6", 8'(credit), 8'd6);
      chk("t2_dreq", 8'(dispense_req), 8'd1);
      dispense_ack = 1'b1; tick(); dispense_ack = 1'b0;
      chk("t2_cr1", 8'(credit), 8'd1);
      chk("t2_nreq", 8'(nickel_out_req), 8'd1);
      chk("t2_dreq0", 8'(dispense_req), 8'd0);
      chk("t2_nodone", 8'(vend_done), 8'd0);
      nickel_out_ack = 1'b1; tick(); nickel_out_ack = 1'b0;
      chk("t2_cr0", 8'(credit), 8'd0);
      chk("t2_nreq0", 8'(nickel_out_req), 8'd0);
      chk("t2_done", 8'(vend_done), 8'd1);
      chk("t2_idle", 8'(busy), 8'd0);

      // Item 1: dime then cancel -> refund two nickels with ack held high.
      select(2'd1);
      dime(); chk("t3_cr2", 8'(credit), 8'd2);
      cancel = 1'b1; tick(); cancel = 1'b0;
      chk("t3_nreq", 8'(nickel_out_req), 8'd1);
      chk("t3_cr2b", 8'(credit), 8'd2);
      nickel_out_ack = 1'b1;
      tick(); chk("t3_cr1", 8'(credit), 8'd1); chk("t3_nreq1", 8'(nickel_out_req), 8'd1);
      tick(); chk("t3_cr0", 8'(credit), 8'd0);
      nickel_out_ack = 1'b0;
      chk("t3_rdone", 8'(refund_done), 8'd1);
      chk("t3_vdone", 8'(vend_done), 8'd0);
      chk("t3_nreq0", 8'(nickel_out_req), 8'd0);
      chk("t3_idle", 8'(busy), 8'd0);
      tick();
      chk("t3_rdone_clr", 8'(refund_done), 8'd0);

      // Cancel with zero credit: back to IDLE, no refund_done.
      select(2'd1);
      cancel = 1'b1; tick(); cancel = 1'b0;
      chk("c0_idle", 8'(busy), 8'd0);
      chk("c0_nordone", 8'(refund_done), 8'd0);

      // Coin reaching price beats same-cycle cancel.
      select(2'd0);
      nickel();
      dime_in = 1'b1; cancel = 1'b1; tick(); dime_in = 1'b0; cancel = 1'b0;
      chk("pc_dreq", 8'(dispense_req), 8'd1);
      chk("pc_cr3", 8'(credit), 8'd3);
      dispense_ack = 1'b1; tick(); dispense_ack = 1'b0;
      chk("pc_done", 8'(vend_done), 8'd1);

      // Invalid item, then simultaneous nickel+dime.
      select(2'd3);
      chk("t4_selerr", 8'(sel_err), 8'd1);
      chk("t4_busy", 8'(busy), 8'd0);
      tick();
      chk("t4_selerr_clr", 8'(sel_err), 8'd0);
      select(2'd0);
      nickel_in = 1'b1; dime_in = 1'b1; tick(); nickel_in = 1'b0; dime_in = 1'b0;
      chk("t4_cr2", 8'(credit), 8'd2);
      chk("t4_rej", 8'(coin_reject), 8'd1);
      tick();
      chk("t4_rej_clr", 8'(coin_reject), 8'd0);

      // Finish into VEND (credit 4), delay ack, coin rejected, then async reset.
      dime();
      chk("t5_dreq", 8'(dispense_req), 8'd1);
      chk("t5_cr4", 8'(credit), 8'd4);
      tick(); tick();
      nickel();
      chk("t5_rej", 8'(coin_reject), 8'd1);
      chk("t5_cr4b", 8'(credit), 8'd4);
      chk("t5_still", 8'(dispense_req), 8'd1);
      #2 reset_n = 1'b0; #1;
      chk("t5_rst_cr", 8'(credit), 8'd0);
      chk("t5_rst_dreq", 8'(dispense_req), 8'd0);
      chk("t5_rst_busy", 8'(busy), 8'd0);
      tick(); reset_n = 1'b1; tick();

`ifdef VEND_TIMEOUT_EN
      // Timeout of 8 cycles: nickel, then 8 idle cycles -> refund one nickel.
      select(2'd0);
      nickel();
      for (int i = 0; i < 7; i++) tick();
      chk("to_wait", 8'(nickel_out_req), 8'd0);
      chk("to_busy", 8'(busy), 8'd1);
      tick();
      chk("to_nreq", 8'(nickel_out_req), 8'd1);
      chk("to_cr1", 8'(credit), 8'd1);
      nickel_out_ack = 1'b1; tick(); nickel_out_ack = 1'b0;
      chk("to_rdone", 8'(refund_done), 8'd1);
      chk("to_idle", 8'(busy), 8'd0);
`else
      // Without the timeout, COLLECT waits indefinitely.
      select(2'd0);
      nickel();
      for (int i = 0; i < 20; i++) tick();
      chk("nt_busy", 8'(busy), 8'd1);
      chk("nt_cr1", 8'(credit), 8'd1);
      chk("nt_nreq", 8'(nickel_out_req), 8'd0);
      cancel = 1'b1; tick(); cancel = 1'b0;
      chk("nt_nreq1", 8'(nickel_out_req), 8'd1);
      nickel_out_ack = 1'b1; tick(); nickel_out_ack = 1'b0;
      chk("nt_rdone", 8'(refund_done), 8'd1);
      chk("nt_idle", 8'(busy), 8'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
